// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/halt controller.
// Imported by the top and by the load-use hazard detector.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } ctrl_state_e;

  localparam int          DEFAULT_DRAIN_CYCLES = 2;
  localparam int          DRAIN_CNT_W          = 8;
  localparam logic [15:0] STALL_CNT_MAX        = 16'hFFFF;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard: the load in EX writes a register that the instruction in ID reads.
// Register 0 is hardwired to zero, so it never creates a dependency.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] dest_reg,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       load_use
);

  assign load_use = mem_read && (dest_reg != 5'd0) &&
                    ((dest_reg == rs) || (dest_reg == rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: stall/flush generation for load-use, branch, jump, memory wait
// and halt, with a halt drain sequence and a saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_if_id,
  input  logic [4:0]  rt_if_id,
  input  logic        MemRead_id_ex,
  input  logic [4:0]  regfile_write_num_id_ex,
  input  logic        branch_taken_ex,
  input  logic [1:0]  Jump_id,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_ex_mem,
  input  logic        resume,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  ctrl_state_e            state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [15:0]            stall_cycles_q, stall_cycles_d;
  logic                   load_use;

  hazard_detect u_hazard_detect (
    .mem_read (MemRead_id_ex),
    .dest_reg (regfile_write_num_id_ex),
    .rs       (rs_if_id),
    .rt       (rt_if_id),
    .load_use (load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      drain_cnt_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Priority in RUN: memory stall, halt, branch, load-use, jump.
  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    halted       = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem} = 4'b1111;
          state_d = ST_MEM_WAIT;
        end else if (halt_ex_mem) begin
          stall_pc    = 1'b1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          drain_cnt_d = DRAIN_LOAD;
          state_d     = ST_DRAIN;
        end else if (branch_taken_ex) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (Jump_id != 2'd0) begin
          flush_if_id = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
        end else begin
          {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem} = 4'b1111;
        end
      end
      ST_DRAIN: begin
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        if (drain_cnt_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
        {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem} = 4'b1111;
        if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Only stalls while fetching or waiting on memory count as lost performance.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_pc && ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) &&
        (stall_cycles_q != STALL_CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-cycle expected outputs are queued
// when stimulus is driven and popped when the DUT outputs are sampled.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mr;
    logic [4:0] wn;
    logic       br;
    logic [1:0] jmp;
    logic       mreq;
    logic       mrdy;
    logic       halt;
    logic       res;
  } stim_t;

  typedef struct packed {
    logic [3:0]  stall;
    logic [1:0]  flush;
    logic        halted;
    logic [1:0]  state;
    logic [15:0] cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_if_id, rt_if_id, regfile_write_num_id_ex;
  logic        MemRead_id_ex, branch_taken_ex, mem_req, mem_ready, halt_ex_mem, resume;
  logic [1:0]  Jump_id;
  logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic        flush_if_id, flush_id_ex, halted;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pipeline_ctrl #(.DRAIN_CYCLES(2)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .rs_if_id                (rs_if_id),
    .rt_if_id                (rt_if_id),
    .MemRead_id_ex           (MemRead_id_ex),
    .regfile_write_num_id_ex (regfile_write_num_id_ex),
    .branch_taken_ex         (branch_taken_ex),
    .Jump_id                 (Jump_id),
    .mem_req                 (mem_req),
    .mem_ready               (mem_ready),
    .halt_ex_mem             (halt_ex_mem),
    .resume                  (resume),
    .stall_pc                (stall_pc),
    .stall_if_id             (stall_if_id),
    .stall_id_ex             (stall_id_ex),
    .stall_ex_mem            (stall_ex_mem),
    .flush_if_id             (flush_if_id),
    .flush_id_ex             (flush_id_ex),
    .halted                  (halted),
    .state                   (state),
    .stall_cycles            (stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t mk(int rs, int rt, int mr, int wn, int br, int jmp,
                               int mreq, int mrdy, int halt, int res);
    stim_t s;
    s.rs = 5'(rs);   s.rt = 5'(rt);     s.mr = 1'(mr);     s.wn = 5'(wn);
    s.br = 1'(br);   s.jmp = 2'(jmp);   s.mreq = 1'(mreq); s.mrdy = 1'(mrdy);
    s.halt = 1'(halt); s.res = 1'(res);
    return s;
  endfunction

  function automatic exp_t ex(int stl, int fl, int h, int st, int c);
    exp_t e;
    e.stall = 4'(stl); e.flush = 2'(fl); e.halted = 1'(h);
    e.state = 2'(st);  e.cyc = 16'(c);
    return e;
  endfunction

  function automatic exp_t observe();
    return exp_t'({stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                   flush_if_id, flush_id_ex, halted, state, stall_cycles});
  endfunction

  task automatic apply_stimulus(input stim_t s, input exp_t e);
    rs_if_id = s.rs;  rt_if_id = s.rt;  MemRead_id_ex = s.mr;
    regfile_write_num_id_ex = s.wn;     branch_taken_ex = s.br;
    Jump_id = s.jmp;  mem_req = s.mreq; mem_ready = s.mrdy;
    halt_ex_mem = s.halt; resume = s.res;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply_stimulus(mk(0,0,0,0,0,0,0,0,0,0), ex(0,0,0,0,0));
    void'(sb.pop_front());
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t got, want;
    rst = 1'b1;
    apply_stimulus(mk(0,0,0,0,0,0,0,0,0,0), ex(0,0,0,0,0));
    #1 got = observe(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL reset_idle: got %h want %h", got, want);
    end
    apply_stimulus(mk(5,0,1,5,0,0,0,0,0,0), ex('b1100,'b01,0,0,0));
    #1 got = observe(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL reset_follow_run: got %h want %h", got, want);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    stim_t s[6];
    exp_t  e[6];
    exp_t  got, want;
    do_reset();
    s[0] = mk(5,0,1,5,0,0,0,0,0,0); e[0] = ex('b1100,'b01,0,0,0);
    s[1] = mk(0,0,0,0,0,0,0,0,0,0); e[1] = ex(0,0,0,0,1);
    s[2] = mk(3,7,1,7,0,0,0,0,0,0); e[2] = ex('b1100,'b01,0,0,1);
    s[3] = mk(5,0,0,5,0,0,0,0,0,0); e[3] = ex(0,0,0,0,2);
    s[4] = mk(0,0,1,0,0,0,0,0,0,0); e[4] = ex(0,0,0,0,2);
    s[5] = mk(0,9,1,0,0,0,0,0,0,0); e[5] = ex(0,0,0,0,2);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(s[i], e[i]);
      #2 got = observe(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL load_use step %0d: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    stim_t s[5];
    exp_t  e[5];
    exp_t  got, want;
    do_reset();
    s[0] = mk(5,0,1,5,1,0,0,0,0,0); e[0] = ex(0,'b11,0,0,0);
    s[1] = mk(0,0,0,0,0,2,0,0,0,0); e[1] = ex(0,'b10,0,0,0);
    s[2] = mk(4,0,1,4,0,1,0,0,0,0); e[2] = ex('b1100,'b01,0,0,0);
    s[3] = mk(0,0,0,0,1,3,0,0,0,0); e[3] = ex(0,'b11,0,0,1);
    s[4] = mk(0,0,0,0,0,0,0,0,0,0); e[4] = ex(0,0,0,0,1);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(s[i], e[i]);
      #2 got = observe(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL branch_jump step %0d: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    stim_t s[9];
    exp_t  e[9];
    exp_t  got, want;
    do_reset();
    s[0] = mk(0,0,0,0,1,0,1,0,0,0); e[0] = ex('b1111,0,0,0,0);
    s[1] = mk(5,0,1,5,1,1,1,0,0,1); e[1] = ex('b1111,0,0,1,1);
    s[2] = mk(0,0,0,0,0,0,1,0,0,0); e[2] = ex('b1111,0,0,1,2);
    s[3] = mk(0,0,0,0,0,0,1,0,0,0); e[3] = ex('b1111,0,0,1,3);
    s[4] = mk(0,0,0,0,0,0,1,1,0,0); e[4] = ex(0,0,0,1,4);
    s[5] = mk(0,0,0,0,0,0,0,0,0,1); e[5] = ex(0,0,0,0,4);
    s[6] = mk(0,0,0,0,0,0,0,0,0,0); e[6] = ex(0,0,0,0,4);
    s[7] = mk(0,0,0,0,0,0,1,1,0,0); e[7] = ex(0,0,0,0,4);
    s[8] = mk(0,0,0,0,0,0,0,0,0,0); e[8] = ex(0,0,0,0,4);
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(s[i], e[i]);
      #2 got = observe(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL mem_wait step %0d: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_resume();
    stim_t s[8];
    exp_t  e[8];
    exp_t  got, want;
    do_reset();
    s[0] = mk(0,0,0,0,0,0,0,0,1,0); e[0] = ex('b1000,'b11,0,0,0);
    s[1] = mk(5,0,1,5,1,1,0,0,1,1); e[1] = ex('b1000,'b11,0,2,1);
    s[2] = mk(0,0,0,0,0,0,0,0,0,0); e[2] = ex('b1000,'b11,0,2,1);
    s[3] = mk(0,0,0,0,0,0,0,0,0,0); e[3] = ex('b1111,0,1,3,1);
    s[4] = mk(5,0,1,5,1,0,0,0,0,0); e[4] = ex('b1111,0,1,3,1);
    s[5] = mk(0,0,0,0,0,0,0,0,0,1); e[5] = ex('b1111,0,1,3,1);
    s[6] = mk(0,0,0,0,0,0,0,0,0,0); e[6] = ex(0,0,0,0,1);
    s[7] = mk(0,0,0,0,0,0,0,0,0,0); e[7] = ex(0,0,0,0,1);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(s[i], e[i]);
      #2 got = observe(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL halt_resume step %0d: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  // Halt arrives while memory is stalling; it must wait until MEM_WAIT ends.
  task automatic test_back_to_back();
    stim_t s[8];
    exp_t  e[8];
    exp_t  got, want;
    do_reset();
    s[0] = mk(0,0,0,0,0,0,1,0,1,0); e[0] = ex('b1111,0,0,0,0);
    s[1] = mk(0,0,0,0,0,0,1,1,1,0); e[1] = ex(0,0,0,1,1);
    s[2] = mk(0,0,0,0,0,0,0,0,1,0); e[2] = ex('b1000,'b11,0,0,1);
    s[3] = mk(0,0,0,0,0,0,0,0,0,0); e[3] = ex('b1000,'b11,0,2,2);
    s[4] = mk(0,0,0,0,0,0,0,0,0,0); e[4] = ex('b1000,'b11,0,2,2);
    s[5] = mk(0,0,0,0,0,0,0,0,0,0); e[5] = ex('b1111,0,1,3,2);
    s[6] = mk(0,0,0,0,0,0,0,0,0,1); e[6] = ex('b1111,0,1,3,2);
    s[7] = mk(0,0,0,0,0,0,0,0,0,0); e[7] = ex(0,0,0,0,2);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(s[i], e[i]);
      #2 got = observe(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL back_to_back step %0d: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_op();
    stim_t s[3];
    exp_t  e[3];
    exp_t  got, want;
    do_reset();
    s[0] = mk(5,0,1,5,0,0,0,0,0,0); e[0] = ex('b1100,'b01,0,0,0);
    s[1] = mk(0,0,0,0,0,0,0,0,1,0); e[1] = ex('b1000,'b11,0,0,1);
    s[2] = mk(0,0,0,0,0,0,0,0,1,0); e[2] = ex('b1000,'b11,0,2,2);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(s[i], e[i]);
      #2 got = observe(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL reset_mid_drain step %0d: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
    // Still in DRAIN here; reset between edges must act immediately.
    apply_stimulus(mk(0,0,0,0,0,0,0,0,1,0), ex('b1000,'b11,0,0,0));
    #2 rst = 1'b1;
    #1 got = observe(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL reset_mid_drain async: got %h want %h", got, want);
    end
    apply_stimulus(mk(0,0,0,0,0,0,0,0,0,0), ex(0,0,0,0,0));
    #1 rst = 1'b0;
    @(posedge clk); #1;
    got = observe(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL reset_mid_drain release: got %h want %h", got, want);
    end
    apply_stimulus(mk(0,0,0,0,0,0,1,0,0,0), ex('b1111,0,0,0,0));
    #2 got = observe(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL reset_mid_memwait enter: got %h want %h", got, want);
    end
    @(posedge clk); #1;
    apply_stimulus(mk(0,0,0,0,0,0,1,0,0,0), ex('b1111,0,0,0,0));
    #2 rst = 1'b1;
    #1 got = observe(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL reset_mid_memwait async: got %h want %h", got, want);
    end
    apply_stimulus(mk(0,0,0,0,0,0,0,0,0,0), ex(0,0,0,0,0));
    #1 rst = 1'b0;
    @(posedge clk); #1;
    got = observe(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL reset_mid_memwait release: got %h want %h", got, want);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_branch_jump();
    test_mem_wait();
    test_halt_resume();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
